// File: rtl/common_defs.sv
// Shared fixed-point types for the vector datapath.
// fp is Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS two's complement.
package common_defs;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;

  typedef logic [DATA_WIDTH-1:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

endpackage

// File: rtl/vector_pkg.sv
// Op and FSM encodings plus the fixed-point multiply
// shared by the vec3 MAC sequencer.
package vector_pkg;
  import common_defs::*;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_DOT   = 2'b10,
    OP_SCALE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_X,
    S_MUL_Y,
    S_MUL_Z,
    S_DONE
  } state_e;

  // Full signed product, floor shift, truncate.
  function automatic fp fp_mul(
    fp  a,
    fp  b,
    int frac = FRAC_BITS
  );
    logic signed [2*DATA_WIDTH-1:0] ea;
    logic signed [2*DATA_WIDTH-1:0] eb;
    logic signed [2*DATA_WIDTH-1:0] p;
    ea = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    eb = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    p  = ea * eb;
    p  = p >>> frac;
    return p[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/vec3_mac_seq_if.sv
// Request/result handshake bundle of the
// vec3 MAC sequencer.
interface vec3_mac_seq_if;
  import common_defs::*;
  import vector_pkg::*;

  logic in_valid;
  logic in_ready;
  op_e  in_op;
  vec3  in_a;
  vec3  in_b;
  fp    in_s;
  logic out_valid;
  logic out_ready;
  vec3  out_vec;
  fp    out_scalar;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_s,
    input  out_ready,
    output in_ready, out_valid,
    output out_vec, out_scalar
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_s,
    output out_ready,
    input  in_ready, out_valid,
    input  out_vec, out_scalar
  );

endinterface

// File: rtl/vec3_mac_seq.sv
// Vec3 ADD/SUB/DOT/SCALE unit sharing one
// multiplier across x, y, z over three cycles.
module vec3_mac_seq
  import common_defs::*;
  import vector_pkg::*;
#(
  parameter int DATA_WIDTH = common_defs::DATA_WIDTH,
  parameter int FRAC_BITS  = common_defs::FRAC_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  vec3_mac_seq_if.slave  bus,
  output logic [15:0]    ops_done
);

  state_e r_state;
  state_e w_next;
  op_e    r_op;
  vec3    r_a;
  vec3    r_b;
  fp      r_s;
  vec3    r_vec;
  fp      r_acc;
  logic [15:0] r_ops;

  logic w_xfer;
  logic w_take;
  logic w_addsub;
  logic [DATA_WIDTH-1:0] w_mul_a;
  logic [DATA_WIDTH-1:0] w_mul_b;
  fp    w_prod;

  assign w_xfer   = bus.in_valid && (r_state == S_IDLE);
  assign w_take   = bus.out_ready && (r_state == S_DONE);
  assign w_addsub = (bus.in_op == OP_ADD) ||
                    (bus.in_op == OP_SUB);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: short path for ADD/SUB, three multiply steps otherwise.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (bus.in_valid)
          w_next = w_addsub ? S_DONE : S_MUL_X;
      S_MUL_X: w_next = S_MUL_Y;
      S_MUL_Y: w_next = S_MUL_Z;
      S_MUL_Z: w_next = S_DONE;
      S_DONE:
        if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Route the active component pair onto the shared multiplier.
  always_comb begin
    w_mul_a = r_a.x;
    w_mul_b = (r_op == OP_SCALE) ? r_s : r_b.x;
    unique case (1'b1)
      r_state == S_MUL_Y: begin
        w_mul_a = r_a.y;
        w_mul_b = (r_op == OP_SCALE) ? r_s : r_b.y;
      end
      r_state == S_MUL_Z: begin
        w_mul_a = r_a.z;
        w_mul_b = (r_op == OP_SCALE) ? r_s : r_b.z;
      end
      default: ;
    endcase
  end

  assign w_prod = fp_mul(w_mul_a, w_mul_b, FRAC_BITS);

  // Operand capture, ADD/SUB result, and multiply writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_ADD;
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_vec <= '0;
      r_acc <= '0;
    end else if (w_xfer) begin
      r_op  <= bus.in_op;
      r_a   <= bus.in_a;
      r_b   <= bus.in_b;
      r_s   <= bus.in_s;
      r_acc <= '0;
      r_vec <= '0;
      if (bus.in_op == OP_ADD) begin
        r_vec.x <= bus.in_a.x + bus.in_b.x;
        r_vec.y <= bus.in_a.y + bus.in_b.y;
        r_vec.z <= bus.in_a.z + bus.in_b.z;
      end else if (bus.in_op == OP_SUB) begin
        r_vec.x <= bus.in_a.x - bus.in_b.x;
        r_vec.y <= bus.in_a.y - bus.in_b.y;
        r_vec.z <= bus.in_a.z - bus.in_b.z;
      end
    end else if (r_op == OP_DOT) begin
      if (r_state == S_MUL_X || r_state == S_MUL_Y ||
          r_state == S_MUL_Z)
        r_acc <= r_acc + w_prod;
    end else begin
      unique case (1'b1)
        r_state == S_MUL_X: r_vec.x <= w_prod;
        r_state == S_MUL_Y: r_vec.y <= w_prod;
        r_state == S_MUL_Z: r_vec.z <= w_prod;
        default: ;
      endcase
    end
  end

  // Count results handed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ops <= '0;
    else if (w_take) r_ops <= r_ops + 16'd1;
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_vec    = r_vec;
  assign bus.out_scalar = r_acc;
  assign ops_done       = r_ops;

endmodule

// File: tb/tb_vec3_mac_seq.sv
// Scoreboard bench for vec3_mac_seq: directed
// corner cases, stall, mid-op reset, random ops.
module tb_vec3_mac_seq;
  import common_defs::*;
  import vector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ops_done;

  vec3_mac_seq_if bus();

  vec3_mac_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    vec3 v;
    fp   s;
    int  tcyc;
    int  lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 1;
  logic [15:0] model_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [95:0] act,
                              logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endfunction

  // Real-valued meaning: floor(a*b / 2^FRAC_BITS) mod 2^32.
  function automatic fp ref_mul(fp a, fp b);
    longint p, d, qq;
    p  = longint'($signed(a)) * longint'($signed(b));
    d  = longint'(1) << FRAC_BITS;
    qq = p / d;
    if (p < 0 && (p % d) != 0) qq = qq - 1;
    return qq[31:0];
  endfunction

  function automatic exp_t model(op_e op, vec3 a, vec3 b, fp s);
    exp_t e;
    e.v = '0;
    e.s = '0;
    e.tcyc = 0;
    e.lat = 4;
    case (op)
      OP_ADD: begin
        e.v.x = a.x + b.x; e.v.y = a.y + b.y; e.v.z = a.z + b.z;
        e.lat = 1;
      end
      OP_SUB: begin
        e.v.x = a.x - b.x; e.v.y = a.y - b.y; e.v.z = a.z - b.z;
        e.lat = 1;
      end
      OP_DOT:
        e.s = ref_mul(a.x, b.x) + ref_mul(a.y, b.y) +
              ref_mul(a.z, b.z);
      default: begin
        e.v.x = ref_mul(a.x, s);
        e.v.y = ref_mul(a.y, s);
        e.v.z = ref_mul(a.z, s);
      end
    endcase
    return e;
  endfunction

  function automatic fp rfp();
    if ($urandom_range(0, 1) == 1) return fp'($urandom);
    return fp'(int'($urandom_range(0, 1 << 21)) - (1 << 20));
  endfunction

  function automatic vec3 rvec();
    vec3 v;
    v.x = rfp(); v.y = rfp(); v.z = rfp();
    return v;
  endfunction

  task automatic send(op_e op, vec3 a, vec3 b, fp s);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_s = s;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready %b want 1", bus.in_ready);
    end else begin
      e = model(op, a, b, s);
      e.tcyc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op = op_e'($urandom_range(0, 3));
    bus.in_a = rvec();
    bus.in_b = rvec();
    bus.in_s = rfp();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d want 0", q.size());
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit  seen;
    vec3 hv;
    fp   hs;
    seen = 0;
    hv = '0;
    hs = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (bus.out_valid) begin
        chk("in_ready_busy", 96'(bus.in_ready), 96'd0);
        if (!seen) begin
          seen = 1;
          hv = bus.out_vec;
          hs = bus.out_scalar;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: vec %h scalar %h want none",
                     bus.out_vec, bus.out_scalar);
          end else begin
            chk("latency", 96'(cyc - q[0].tcyc + 1), 96'(q[0].lat));
          end
        end else begin
          chk("stable_vec", bus.out_vec, hv);
          chk("stable_scalar", 96'(bus.out_scalar), 96'(hs));
        end
        if (bus.out_ready) begin
          if (q.size() > 0) begin
            chk("out_vec", bus.out_vec, q[0].v);
            chk("out_scalar", 96'(bus.out_scalar), 96'(q[0].s));
            chk("ops_done", 96'(ops_done), 96'(model_cnt));
            void'(q.pop_front());
          end
          model_cnt = model_cnt + 16'd1;
          seen = 0;
        end
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec3 a, b, z;
    logic [15:0] o;
    int n;
    z = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = OP_ADD;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_s = '0;
    #12;
    chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst_out_vec", bus.out_vec, 96'd0);
    chk("rst_out_scalar", 96'(bus.out_scalar), 96'd0);
    chk("rst_ops_done", 96'(ops_done), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 96'(bus.in_ready), 96'd1);

    a = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    b = '{32'h0004_0000, 32'h0005_0000, 32'h0006_0000};
    send(OP_DOT, a, b, 32'h0);
    a = '{32'h0001_0000, 32'hFFFE_0000, 32'h0000_8000};
    send(OP_SCALE, a, rvec(), 32'h0002_0000);
    a = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
    b = '{32'h0000_0001, 32'h0, 32'hFFFF_FFFF};
    send(OP_ADD, a, b, 32'h0);
    send(OP_SUB, b, a, 32'h0);
    a = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    send(OP_SCALE, a, z, 32'h0000_8000);
    drain();

    rdy_mode = 0;
    send(OP_ADD, rvec(), rvec(), rfp());
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", 96'(bus.out_valid), 96'd1);
    o = ops_done;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ops", 96'(ops_done), 96'(o));
      chk("stall_in_ready", 96'(bus.in_ready), 96'd0);
    end
    rdy_mode = 1;
    drain();
    @(negedge clk);
    chk("stall_ops_inc", 96'(ops_done), 96'(o + 16'd1));

    send(OP_DOT, rvec(), rvec(), rfp());
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 96'(bus.out_valid), 96'd0);
    chk("midrst_vec", bus.out_vec, 96'd0);
    chk("midrst_scalar", 96'(bus.out_scalar), 96'd0);
    chk("midrst_ops", 96'(ops_done), 96'd0);
    q.delete();
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 96'(bus.in_ready), 96'd1);
    a = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    b = '{32'h0004_0000, 32'h0005_0000, 32'h0006_0000};
    send(OP_DOT, a, b, 32'h0);
    drain();

    rdy_mode = 2;
    repeat (80)
      send(op_e'($urandom_range(0, 3)), rvec(), rvec(), rfp());
    drain();
    rdy_mode = 1;
    @(negedge clk);
    chk("final_ops_done", 96'(ops_done), 96'(model_cnt));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
